div_sequencer: RTL and testbench

//   Clocked controller that shares one WIDTH-bit unsigned non-restoring divide datapath between two requesters.

---
 rtl/div_sequencer_if.sv | 28 ++
 rtl/div_sequencer.sv | 159 +++++++++++++++
 tb/tb_div_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Requester-side handshake and result bus of the shared divider.
// The master modport is the ALU issue side; the slave modport is the sequencer.
interface div_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       req;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output req, a0, b0, a1, b1,
    input  gnt, busy, done, done_id, quotient, remainder, div_by_zero
  );

  modport slave (
    input  req, a0, b0, a1, b1,
    output gnt, busy, done, done_id, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// Round-robin shared non-restoring divider: one iteration per clock, final
// remainder fix-up, result returned with a done pulse tagged by requester id.
module div_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  div_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   b_reg;
  logic [WIDTH-1:0] a_reg;
  logic [CW-1:0]    count;
  logic             last_id;
  logic             cur_id;

  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  logic [1:0]       gnt;
  logic             grant_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH:0]   p_fix;

  // Grant is combinational so the requester sees it in the same cycle its operands are latched.
  always_comb begin
    gnt      = 2'b00;
    grant_id = 1'b0;
    if (state == IDLE) begin
      case (bus.req)
        2'b01: begin
          gnt      = 2'b01;
          grant_id = 1'b0;
        end
        2'b10: begin
          gnt      = 2'b10;
          grant_id = 1'b1;
        end
        2'b11: begin
          grant_id = ~last_id;
          gnt      = last_id ? 2'b01 : 2'b10;
        end
        default: begin
          gnt      = 2'b00;
          grant_id = 1'b0;
        end
      endcase
    end
  end

  assign sel_a = grant_id ? bus.a1 : bus.a0;
  assign sel_b = grant_id ? bus.b1 : bus.b0;

  // Add/subtract decision uses the sign of P before the shift; the spare P bit absorbs wrap.
  always_comb begin
    p_shift = {p[WIDTH-1:0], a_reg[WIDTH-1]};
    p_next  = p[WIDTH] ? (p_shift + b_reg) : (p_shift - b_reg);
    a_next  = {a_reg[WIDTH-2:0], ~p_next[WIDTH]};
    p_fix   = p[WIDTH] ? (p + b_reg) : p;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      p           <= '0;
      b_reg       <= '0;
      a_reg       <= '0;
      count       <= '0;
      last_id     <= 1'b1;
      cur_id      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            last_id <= grant_id;
            cur_id  <= grant_id;
            a_reg   <= sel_a;
            b_reg   <= {1'b0, sel_b};
            p       <= '0;
            count   <= '0;
            busy    <= 1'b1;
            if (sel_b == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              done_id     <= grant_id;
              quotient    <= '1;
              remainder   <= sel_a;
              div_by_zero <= 1'b1;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          p     <= p_next;
          a_reg <= a_next;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            state <= FIX;
          end
        end
        // Results are loaded on entry to DONE so they are valid alongside the done pulse.
        FIX: begin
          p           <= p_fix;
          state       <= DONE;
          done        <= 1'b1;
          done_id     <= cur_id;
          quotient    <= a_reg;
          remainder   <= p_fix[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.done_id     = done_id;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomised self-checking bench for div_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div_sequencer;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  div_if #(.WIDTH(WIDTH)) bus ();

  div_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Directed vectors: requester, dividend, divisor, quotient, remainder, div-by-zero, latency.
  logic        v_id  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] v_a   [9] = '{16'd100, 16'hFFFF, 16'hFFFF, 16'd3, 16'd5, 16'd1000, 16'd0, 16'hFFFF, 16'd7};
  logic [15:0] v_b   [9] = '{16'd7, 16'd1, 16'h8001, 16'd10, 16'd0, 16'd33, 16'd5, 16'hFFFF, 16'd0};
  logic [15:0] v_q   [9] = '{16'd14, 16'hFFFF, 16'd1, 16'd0, 16'hFFFF, 16'd30, 16'd0, 16'd1, 16'hFFFF};
  logic [15:0] v_r   [9] = '{16'd2, 16'd0, 16'h7FFE, 16'd3, 16'd5, 16'd10, 16'd0, 16'd0, 16'd7};
  logic        v_dbz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int          v_lat [9] = '{18, 18, 18, 18, 1, 18, 18, 18, 1};

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 2'b00;
    bus.a0  = '0;
    bus.b0  = '0;
    bus.a1  = '0;
    bus.b1  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", bus.done); else passed++;
    checks++; if (bus.done_id !== 1'b0) $display("[TB] FAIL reset_done_id got %b want 0", bus.done_id); else passed++;
    checks++; if (bus.quotient !== 16'h0) $display("[TB] FAIL reset_quotient got %h want 0000", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 16'h0) $display("[TB] FAIL reset_remainder got %h want 0000", bus.remainder); else passed++;
    checks++; if (bus.div_by_zero !== 1'b0) $display("[TB] FAIL reset_dbz got %b want 0", bus.div_by_zero); else passed++;
    checks++; if (bus.gnt !== 2'b00) $display("[TB] FAIL reset_gnt got %b want 00", bus.gnt); else passed++;
  endtask

  task automatic test_single_divides();
    int cyc;
    logic [1:0] want_gnt;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (v_id[i]) begin
        bus.a1 = v_a[i];
        bus.b1 = v_b[i];
      end else begin
        bus.a0 = v_a[i];
        bus.b0 = v_b[i];
      end
      want_gnt = v_id[i] ? 2'b10 : 2'b01;
      bus.req  = want_gnt;
      #1;
      checks++; if (bus.gnt !== want_gnt) $display("[TB] FAIL vec%0d_gnt got %b want %b", i, bus.gnt, want_gnt); else passed++;
      @(posedge clk);
      @(negedge clk);
      bus.req = 2'b00;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      checks++; if (cyc !== v_lat[i]) $display("[TB] FAIL vec%0d_latency got %0d want %0d", i, cyc, v_lat[i]); else passed++;
      checks++; if (bus.quotient !== v_q[i]) $display("[TB] FAIL vec%0d_quotient got %h want %h", i, bus.quotient, v_q[i]); else passed++;
      checks++; if (bus.remainder !== v_r[i]) $display("[TB] FAIL vec%0d_remainder got %h want %h", i, bus.remainder, v_r[i]); else passed++;
      checks++; if (bus.div_by_zero !== v_dbz[i]) $display("[TB] FAIL vec%0d_dbz got %b want %b", i, bus.div_by_zero, v_dbz[i]); else passed++;
      checks++; if (bus.done_id !== v_id[i]) $display("[TB] FAIL vec%0d_done_id got %b want %b", i, bus.done_id, v_id[i]); else passed++;
      checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL vec%0d_busy_at_done got %b want 1", i, bus.busy); else passed++;
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) $display("[TB] FAIL vec%0d_done_pulse got %b want 0", i, bus.done); else passed++;
      checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL vec%0d_busy_after got %b want 0", i, bus.busy); else passed++;
      checks++; if (bus.quotient !== v_q[i]) $display("[TB] FAIL vec%0d_quotient_hold got %h want %h", i, bus.quotient, v_q[i]); else passed++;
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    int stray_gnt;
    do_reset();
    @(negedge clk);
    bus.a0  = 16'd100;
    bus.b0  = 16'd7;
    bus.a1  = 16'd9;
    bus.b1  = 16'd3;
    bus.req = 2'b11;
    #1;
    checks++; if (bus.gnt !== 2'b01) $display("[TB] FAIL rr_first_gnt got %b want 01", bus.gnt); else passed++;
    @(posedge clk);
    @(negedge clk);
    bus.req   = 2'b10;
    cyc       = 1;
    stray_gnt = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      #1;
      if (bus.gnt !== 2'b00) stray_gnt++;
      @(negedge clk);
      cyc++;
    end
    #1;
    if (bus.gnt !== 2'b00) stray_gnt++;
    checks++; if (stray_gnt !== 0) $display("[TB] FAIL rr_gnt_while_busy got %0d cycles want 0", stray_gnt); else passed++;
    checks++; if (cyc !== 18) $display("[TB] FAIL rr_first_latency got %0d want 18", cyc); else passed++;
    checks++; if (bus.done_id !== 1'b0) $display("[TB] FAIL rr_first_done_id got %b want 0", bus.done_id); else passed++;
    checks++; if (bus.quotient !== 16'd14) $display("[TB] FAIL rr_first_quotient got %0d want 14", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 16'd2) $display("[TB] FAIL rr_first_remainder got %0d want 2", bus.remainder); else passed++;
    @(negedge clk);
    #1;
    checks++; if (bus.gnt !== 2'b10) $display("[TB] FAIL rr_second_gnt got %b want 10", bus.gnt); else passed++;
    @(posedge clk);
    @(negedge clk);
    bus.req = 2'b00;
    cyc     = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 18) $display("[TB] FAIL rr_second_latency got %0d want 18", cyc); else passed++;
    checks++; if (bus.done_id !== 1'b1) $display("[TB] FAIL rr_second_done_id got %b want 1", bus.done_id); else passed++;
    checks++; if (bus.quotient !== 16'd3) $display("[TB] FAIL rr_second_quotient got %0d want 3", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 16'd0) $display("[TB] FAIL rr_second_remainder got %0d want 0", bus.remainder); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_divide();
    int cyc;
    int dones;
    @(negedge clk);
    bus.a0  = 16'd100;
    bus.b0  = 16'd7;
    bus.req = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.req = 2'b00;
    cyc = 1;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL abort_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL abort_done got %b want 0", bus.done); else passed++;
    checks++; if (bus.done_id !== 1'b0) $display("[TB] FAIL abort_done_id got %b want 0", bus.done_id); else passed++;
    checks++; if (bus.quotient !== 16'h0) $display("[TB] FAIL abort_quotient got %h want 0000", bus.quotient); else passed++;
    checks++; if (bus.remainder !== 16'h0) $display("[TB] FAIL abort_remainder got %h want 0000", bus.remainder); else passed++;
    checks++; if (bus.div_by_zero !== 1'b0) $display("[TB] FAIL abort_dbz got %b want 0", bus.div_by_zero); else passed++;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0) dones++;
    end
    checks++; if (dones !== 0) $display("[TB] FAIL abort_no_done got %0d dones want 0", dones); else passed++;
  endtask

  task automatic test_random();
    int          done_cnt;
    int          cyc;
    int          since_grant;
    logic        model_idle;
    logic        last_id;
    logic        inflight;
    logic        pend_drop;
    logic        pend_id;
    logic        saw_done;
    logic        gid;
    logic [1:0]  eg;
    logic [15:0] eq;
    logic [15:0] er;
    logic        edbz;
    logic        eid;
    logic [15:0] na;
    logic [15:0] nb;
    logic [15:0] ga;
    logic [15:0] gb;
    do_reset();
    model_idle  = 1'b1;
    last_id     = 1'b1;
    inflight    = 1'b0;
    pend_drop   = 1'b0;
    pend_id     = 1'b0;
    since_grant = 0;
    done_cnt    = 0;
    cyc         = 0;
    eq = '0; er = '0; edbz = 1'b0; eid = 1'b0;
    while (done_cnt < 2000 && cyc < 95000) begin
      @(negedge clk);
      cyc++;
      if (pend_drop) begin
        bus.req[pend_id] = 1'b0;
        pend_drop = 1'b0;
      end
      saw_done = (bus.done === 1'b1);
      if (saw_done) begin
        checks++;
        if (!inflight || {bus.quotient, bus.remainder, bus.div_by_zero, bus.done_id} !== {eq, er, edbz, eid})
          $display("[TB] FAIL rand_result#%0d got q=%h r=%h dbz=%b id=%b want q=%h r=%h dbz=%b id=%b inflight=%b",
                   done_cnt, bus.quotient, bus.remainder, bus.div_by_zero, bus.done_id, eq, er, edbz, eid, inflight);
        else passed++;
        inflight = 1'b0;
        done_cnt++;
      end
      if (inflight) begin
        since_grant++;
        if (since_grant > WIDTH + 4) begin
          checks++;
          $display("[TB] FAIL rand_timeout got no done after %0d cycles want done within %0d", since_grant, WIDTH + 2);
          break;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.req[i]) begin
          if ($urandom_range(15) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          na = 16'($urandom);
          case ($urandom_range(7))
            0:       nb = 16'd0;
            1, 2:    nb = 16'($urandom_range(15, 1));
            default: nb = 16'($urandom);
          endcase
          if (i == 0) begin
            bus.a0 = na;
            bus.b0 = nb;
          end else begin
            bus.a1 = na;
            bus.b1 = nb;
          end
          bus.req[i] = 1'b1;
        end
      end
      #1;
      eg = 2'b00;
      if (model_idle) begin
        case (bus.req)
          2'b01:   eg = 2'b01;
          2'b10:   eg = 2'b10;
          2'b11:   eg = last_id ? 2'b01 : 2'b10;
          default: eg = 2'b00;
        endcase
      end
      checks++;
      if (bus.gnt !== eg) $display("[TB] FAIL rand_gnt cycle %0d got %b want %b req=%b", cyc, bus.gnt, eg, bus.req);
      else passed++;
      if (eg != 2'b00) begin
        gid  = eg[1];
        ga   = gid ? bus.a1 : bus.a0;
        gb   = gid ? bus.b1 : bus.b0;
        eq   = (gb == 16'd0) ? 16'hFFFF : ga / gb;
        er   = (gb == 16'd0) ? ga : ga % gb;
        edbz = (gb == 16'd0);
        eid  = gid;
        last_id     = gid;
        inflight    = 1'b1;
        since_grant = 0;
        model_idle  = 1'b0;
        pend_drop   = 1'b1;
        pend_id     = gid;
      end
      if (saw_done) model_idle = 1'b1;
    end
    checks++;
    if (done_cnt !== 2000) $display("[TB] FAIL rand_count got %0d divides want 2000", done_cnt); else passed++;
    bus.req = 2'b00;
  endtask

  initial begin
    bus.req = 2'b00;
    bus.a0  = '0;
    bus.b0  = '0;
    bus.a1  = '0;
    bus.b1  = '0;
    test_reset();
    test_single_divides();
    test_round_robin();
    test_reset_mid_divide();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
